// File: rtl/forwardmux1.sv
// forwardmux1: select encoding for the EX-stage operand-1 forwarding mux
package forwardmux1;
  typedef enum logic [1:0] {
    idex_rs1reg_out  = 2'b00,
    exmem_alureg_out = 2'b01,
    regfilemux_out   = 2'b10
  } forwardmux1_sel_t;
endpackage

// File: rtl/forwardmux2.sv
// forwardmux2: select encoding for the EX-stage operand-2 forwarding mux
package forwardmux2;
  typedef enum logic [1:0] {
    idex_rs2reg_out  = 2'b00,
    exmem_alureg_out = 2'b01,
    regfilemux_out   = 2'b10
  } forwardmux2_sel_t;
endpackage

// File: rtl/hazard_types.sv
// hazard_types: sequencing states and raw forwarding codes shared by the hazard controller
package hazard_types;
  typedef enum logic [1:0] {RUN, WAIT_BOTH, WAIT_I, WAIT_D} hz_state_t;
  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_WB    = 2'b10;
endpackage

// File: rtl/pcmux.sv
// pcmux: select encoding for the next-PC mux
package pcmux;
  typedef enum logic {
    pc_plus4 = 1'b0,
    alu_out  = 1'b1
  } pcmux_sel_t;
endpackage

// File: rtl/fwd_detect.sv
// fwd_detect: forwarding source for one EX operand, EX/MEM result wins over MEM/WB
module fwd_detect
  import hazard_types::*;
(
  input  logic [4:0] i_ex_rs,
  input  logic [4:0] i_mem_rd,
  input  logic       i_mem_regwrite,
  input  logic [4:0] i_wb_rd,
  input  logic       i_wb_regwrite,
  output logic [1:0] o_sel
);
  // x0 is never forwarded since it always reads as zero
  always_comb
    o_sel = (i_mem_regwrite && i_mem_rd != 5'd0 && i_mem_rd == i_ex_rs) ? FWD_EXMEM :
            (i_wb_regwrite && i_wb_rd != 5'd0 && i_wb_rd == i_ex_rs) ? FWD_WB : FWD_NONE;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: forwarding, stall/flush sequencing and split I/D memory wait tracking
module pipeline_hazard_ctrl
  import hazard_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_is_load,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  input  logic             ex_br_taken,
  input  logic             imem_resp,
  input  logic             dmem_op,
  input  logic             dmem_resp,
  output logic [1:0]       fwd1_sel,
  output logic [1:0]       fwd2_sel,
  output logic             pcmux_sel,
  output logic             ld_pc,
  output logic             ld_ifid,
  output logic             ld_idex,
  output logic             ld_exmem,
  output logic             ld_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             imem_req_en,
  output logic             dmem_req_en,
  output logic             ihold_ld,
  output logic             dhold_ld,
  output logic             use_ihold,
  output logic             use_dhold,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush
);
  hz_state_t r_state, w_next;
  logic r_i_done, r_d_done;
  logic [1:0] w_sel1, w_sel2;
  forwardmux1::forwardmux1_sel_t w_fwd1;
  forwardmux2::forwardmux2_sel_t w_fwd2;
  logic w_i_wait, w_d_wait, w_freeze, w_adv, w_lu, w_br, w_lu_stall, w_ihold, w_dhold;

  fwd_detect u_fwd1 (
    .i_ex_rs(ex_rs1), .i_mem_rd(mem_rd), .i_mem_regwrite(mem_regwrite),
    .i_wb_rd(wb_rd), .i_wb_regwrite(wb_regwrite), .o_sel(w_sel1)
  );
  fwd_detect u_fwd2 (
    .i_ex_rs(ex_rs2), .i_mem_rd(mem_rd), .i_mem_regwrite(mem_regwrite),
    .i_wb_rd(wb_rd), .i_wb_regwrite(wb_regwrite), .o_sel(w_sel2)
  );

  assign w_fwd1     = forwardmux1::forwardmux1_sel_t'(w_sel1);
  assign w_fwd2     = forwardmux2::forwardmux2_sel_t'(w_sel2);
  assign w_i_wait   = ~r_i_done & ~imem_resp;
  assign w_d_wait   = dmem_op & ~r_d_done & ~dmem_resp;
  assign w_adv      = ~w_freeze;
  assign w_lu       = ex_is_load && ex_rd != 5'd0 &&
                      ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  assign w_br       = w_adv & ex_br_taken;
  assign w_lu_stall = w_adv & ~ex_br_taken & w_lu;
  assign w_ihold    = imem_resp & ~r_i_done & w_freeze;
  assign w_dhold    = dmem_resp & dmem_op & ~r_d_done & w_freeze;

  // Single-port waits only watch their own response; RUN and WAIT_BOTH re-evaluate both ports
  always_comb begin
    w_next   = RUN;
    w_freeze = 1'b0;
    case (r_state)
      WAIT_I: begin
        w_freeze = ~imem_resp;
        w_next   = imem_resp ? RUN : WAIT_I;
      end
      WAIT_D: begin
        w_freeze = ~dmem_resp;
        w_next   = dmem_resp ? RUN : WAIT_D;
      end
      default: begin
        w_freeze = w_i_wait | w_d_wait;
        w_next   = (w_i_wait && w_d_wait) ? WAIT_BOTH : w_i_wait ? WAIT_I : w_d_wait ? WAIT_D : RUN;
      end
    endcase
  end

  // Pipeline controls, all forced to their idle values while reset is held
  always_comb begin
    fwd1_sel    = rst_n ? w_fwd1 : forwardmux1::idex_rs1reg_out;
    fwd2_sel    = rst_n ? w_fwd2 : forwardmux2::idex_rs2reg_out;
    pcmux_sel   = (rst_n && w_br) ? pcmux::alu_out : pcmux::pc_plus4;
    ld_pc       = rst_n & w_adv & ~w_lu_stall;
    ld_ifid     = rst_n & w_adv & ~w_lu_stall;
    ld_idex     = rst_n & w_adv;
    ld_exmem    = rst_n & w_adv;
    ld_memwb    = rst_n & w_adv;
    flush_ifid  = rst_n & w_br;
    flush_idex  = rst_n & (w_br | w_lu_stall);
    imem_req_en = rst_n & ~r_i_done;
    dmem_req_en = rst_n & ~r_d_done;
    ihold_ld    = rst_n & w_ihold;
    dhold_ld    = rst_n & w_dhold;
    use_ihold   = rst_n & w_adv & r_i_done;
    use_dhold   = rst_n & w_adv & r_d_done;
  end

  // State, captured-response flags (cleared by the advance) and saturating counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= RUN;
      r_i_done  <= 1'b0;
      r_d_done  <= 1'b0;
      cnt_stall <= '0;
      cnt_flush <= '0;
    end else begin
      r_state  <= w_next;
      r_i_done <= w_freeze & (r_i_done | w_ihold);
      r_d_done <= w_freeze & (r_d_done | w_dhold);
      if ((w_freeze | w_lu_stall) && cnt_stall != '1) cnt_stall <= cnt_stall + CNT_W'(1);
      if (w_br && cnt_flush != '1) cnt_flush <= cnt_flush + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scoreboard bench for the hazard controller (CNT_W=4 build)
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_regwrite, ex_is_load, mem_regwrite, wb_regwrite;
  logic ex_br_taken, imem_resp, dmem_op, dmem_resp;
  logic [1:0] fwd1_sel, fwd2_sel;
  logic pcmux_sel, ld_pc, ld_ifid, ld_idex, ld_exmem, ld_memwb, flush_ifid, flush_idex;
  logic imem_req_en, dmem_req_en, ihold_ld, dhold_ld, use_ihold, use_dhold;
  logic [3:0] cnt_stall, cnt_flush;
  int checks = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [17:0] ctl;
    logic [3:0]  stall;
    logic [3:0]  flush;
  } exp_t;
  exp_t sb[$];

  logic [17:0] obs;
  logic [17:0] norm, frz, lu, br, icap, dcap, dwait, dadv, iadv;

  pipeline_hazard_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .ex_br_taken(ex_br_taken), .imem_resp(imem_resp), .dmem_op(dmem_op), .dmem_resp(dmem_resp),
    .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .pcmux_sel(pcmux_sel),
    .ld_pc(ld_pc), .ld_ifid(ld_ifid), .ld_idex(ld_idex), .ld_exmem(ld_exmem), .ld_memwb(ld_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .imem_req_en(imem_req_en), .dmem_req_en(dmem_req_en),
    .ihold_ld(ihold_ld), .dhold_ld(dhold_ld), .use_ihold(use_ihold), .use_dhold(use_dhold),
    .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
  );

  always #5 clk = ~clk;

  assign obs = {fwd1_sel, fwd2_sel, pcmux_sel, ld_pc, ld_ifid, ld_idex, ld_exmem, ld_memwb,
                flush_ifid, flush_idex, imem_req_en, dmem_req_en, ihold_ld, dhold_ld, use_ihold, use_dhold};

  function automatic logic [17:0] mk(input logic [1:0] f1, input logic [1:0] f2, input logic pc,
                                     input logic [4:0] ld, input logic [1:0] fl, input logic [1:0] rq,
                                     input logic [1:0] hd, input logic [1:0] us);
    return {f1, f2, pc, ld, fl, rq, hd, us};
  endfunction

  task automatic step(input string tag, input logic [17:0] ctl, input int st, input int fl);
    exp_t e;
    e.tag = tag;
    e.ctl = ctl;
    e.stall = 4'(st);
    e.flush = 4'(fl);
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    checks++;
    assert (obs === e.ctl) else begin
      failures++;
      $error("FAIL %s ctl observed=%b expected=%b", e.tag, obs, e.ctl);
    end
    @(posedge clk);
    #1;
    checks++;
    assert ({cnt_stall, cnt_flush} === {e.stall, e.flush}) else begin
      failures++;
      $error("FAIL %s_cnt stall/flush observed=%0d/%0d expected=%0d/%0d", e.tag, cnt_stall, cnt_flush, e.stall, e.flush);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    norm  = mk(0, 0, 0, 5'h1f, 0, 2'b11, 0, 0);
    frz   = mk(0, 0, 0, 5'h00, 0, 2'b11, 0, 0);
    lu    = mk(0, 0, 0, 5'b00111, 2'b01, 2'b11, 0, 0);
    br    = mk(0, 0, 1, 5'h1f, 2'b11, 2'b11, 0, 0);
    icap  = mk(0, 0, 0, 5'h00, 0, 2'b11, 2'b10, 0);
    dcap  = mk(0, 0, 0, 5'h00, 0, 2'b11, 2'b01, 0);
    dwait = mk(0, 0, 0, 5'h00, 0, 2'b10, 0, 0);
    dadv  = mk(0, 0, 0, 5'h1f, 0, 2'b10, 0, 2'b01);
    iadv  = mk(0, 0, 0, 5'h1f, 0, 2'b01, 0, 2'b10);
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_regwrite, ex_is_load, mem_regwrite, wb_regwrite} = '0;
    rst_n = 1'b0; ex_br_taken = 1'b1; imem_resp = 1'b1; dmem_op = 1'b0; dmem_resp = 1'b0;
    #1;
    step("rst", 18'd0, 0, 0);
    step("rst2", 18'd0, 0, 0);
    rst_n = 1'b1; ex_br_taken = 1'b0;
    step("run", norm, 0, 0);
    ex_rs1 = 5; mem_rd = 5; mem_regwrite = 1; wb_rd = 5; wb_regwrite = 1;
    step("fwd1_exmem", mk(2'b01, 0, 0, 5'h1f, 0, 2'b11, 0, 0), 0, 0);
    mem_rd = 0;
    step("fwd1_wb", mk(2'b10, 0, 0, 5'h1f, 0, 2'b11, 0, 0), 0, 0);
    ex_rs1 = 0; ex_rs2 = 9; mem_rd = 9; mem_regwrite = 0; wb_rd = 9;
    step("fwd2_wb", mk(0, 2'b10, 0, 5'h1f, 0, 2'b11, 0, 0), 0, 0);
    mem_regwrite = 1;
    step("fwd2_exmem", mk(0, 2'b01, 0, 5'h1f, 0, 2'b11, 0, 0), 0, 0);
    ex_rs2 = 0; mem_rd = 0; wb_rd = 0;
    step("fwd_x0", norm, 0, 0);
    mem_regwrite = 0; wb_regwrite = 0;
    ex_is_load = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
    step("load_use", lu, 1, 0);
    id_use_rs2 = 0;
    step("lu_nouse", norm, 1, 0);
    id_rs1 = 7; id_use_rs1 = 1;
    step("lu_rs1", lu, 2, 0);
    ex_rd = 0; id_rs1 = 0;
    step("lu_x0", norm, 2, 0);
    ex_rd = 7; id_use_rs2 = 1; ex_br_taken = 1;
    step("branch", br, 2, 1);
    ex_br_taken = 0; ex_is_load = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_rd = 0; id_rs2 = 0;
    rst_n = 0;
    step("rst3", 18'd0, 0, 0);
    rst_n = 1; dmem_op = 1; imem_resp = 0; dmem_resp = 0;
    step("d_c0", frz, 1, 0);
    ex_br_taken = 1;
    step("d_c1", frz, 2, 0);
    ex_br_taken = 0; dmem_resp = 1;
    step("d_c2", dcap, 3, 0);
    dmem_resp = 0;
    step("d_c3", dwait, 4, 0);
    step("d_c4", dwait, 5, 0);
    imem_resp = 1;
    step("d_c5_adv", dadv, 5, 0);
    dmem_op = 0;
    step("d_after", norm, 5, 0);
    dmem_op = 1;
    step("i_cap", icap, 6, 0);
    imem_resp = 0; dmem_resp = 1;
    step("i_adv", iadv, 6, 0);
    dmem_resp = 0;
    step("both_w", frz, 7, 0);
    imem_resp = 1; dmem_resp = 1;
    step("both_adv", norm, 7, 0);
    imem_resp = 0; dmem_resp = 0;
    step("wb_enter", frz, 8, 0);
    rst_n = 0;
    step("wb_rst", 18'd0, 0, 0);
    rst_n = 1; dmem_op = 0; imem_resp = 1;
    step("wb_rel", norm, 0, 0);
    dmem_op = 1;
    step("fl_cap", icap, 1, 0);
    rst_n = 0;
    step("fl_rst", 18'd0, 0, 0);
    rst_n = 1; imem_resp = 0; dmem_resp = 1;
    step("fl_rel", dcap, 1, 0);
    imem_resp = 1; dmem_resp = 0;
    step("fl_adv", dadv, 1, 0);
    dmem_op = 0; imem_resp = 0;
    for (int i = 1; i <= 20; i++) step("sat_stall", frz, (i + 1 > 15) ? 15 : i + 1, 0);
    imem_resp = 1;
    step("sat_end", norm, 15, 0);
    ex_br_taken = 1;
    for (int i = 1; i <= 18; i++) step("sat_flush", br, 15, (i > 15) ? 15 : i);
    ex_br_taken = 0;
    step("final", norm, 15, 15);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
